eci_hdr_rr_arb: RTL and testbench
=================================

ECI_HDR_RR_ARB -- requirements
Module: eci_hdr_rr_arb

Interface
REQ-001: Parameters SHALL be: NUM_SRC, default 4, number of requesters (2..8); HDR_WIDTH, default 64, header width; SIZE_WIDTH, default 5, packet-size width; CNT_WIDTH, default 16, packet-counter width.
REQ-002: clk  in  1  single clock for all logic.
REQ-003: reset  in  1  asynchronous, active-high reset.
REQ-004: src_hdr_i  in  NUM_SRC*HDR_WIDTH  per-source header; source k occupies bits [k*HDR_WIDTH +: HDR_WIDTH].
REQ-005: src_pkt_size_i  in  NUM_SRC*SIZE_WIDTH  per-source packet size.
REQ-006: src_pkt_vc_i  in  NUM_SRC*4  per-source VC number.
REQ-007: src_pkt_valid_i  in  NUM_SRC  per-source valid.
REQ-008: src_pkt_ready_o  out  NUM_SRC  per-source ready (one-hot or zero).
REQ-009: vc_block_i  in  16  bit v=1 marks VC v ineligible this cycle.
REQ-010: hdr_o  out  HDR_WIDTH  merged header.
REQ-011: pkt_size_o  out  SIZE_WIDTH  merged size.
REQ-012: pkt_vc_o  out  4  merged VC.
REQ-013: pkt_src_o  out  clog2(NUM_SRC)  index of the winning source.
REQ-014: pkt_valid_o  out  1  merged valid.
REQ-015: pkt_ready_i  in  1  downstream ready.
REQ-016: pkt_cnt_o  out  CNT_WIDTH  number of packets accepted from the sources.

Function
REQ-017: Source k SHALL be eligible when src_pkt_valid_i[k]=1 and vc_block_i[src_pkt_vc_i[k]]=0.
REQ-018: The output SHALL be one register stage; load_en = !pkt_valid_o || pkt_ready_i.
REQ-019: When load_en=1, the arbiter SHALL grant the first eligible source found by searching upward from rr_ptr, wrapping modulo NUM_SRC.
REQ-020: src_pkt_ready_o[k] SHALL be combinational and equal 1 only for the granted source while load_en=1; otherwise all ready bits SHALL be 0.
REQ-021: On a grant to k, hdr/size/vc/src SHALL be registered on the next edge, pkt_valid_o SHALL be 1, and rr_ptr SHALL become (k+1) mod NUM_SRC.
REQ-022: If load_en=1 and no source is eligible, pkt_valid_o SHALL become 0 and rr_ptr SHALL hold.
REQ-023: While pkt_valid_o=1 and pkt_ready_i=0, all output fields SHALL stay stable and no source SHALL be granted.
REQ-024: Latency from source handshake to pkt_valid_o SHALL be 1 cycle; with pkt_ready_i held at 1, sustained throughput SHALL be 1 packet per cycle.
REQ-025: Downstream accept and new load in the same cycle SHALL replace the output without a bubble.
REQ-026: pkt_cnt_o SHALL increment by 1 on every source handshake and wrap from all-ones to 0.
REQ-027: vc_block_i SHALL gate only new grants; a packet already registered SHALL not be withdrawn.
REQ-028: No source SHALL wait more than NUM_SRC-1 grants while it stays eligible.

Reset
REQ-029: On reset assertion, asynchronously: pkt_valid_o=0, rr_ptr=0, pkt_cnt_o=0, hdr_o/pkt_size_o/pkt_vc_o/pkt_src_o=0.
REQ-030: While reset=1, src_pkt_ready_o SHALL be 0.
REQ-031: A packet held in the output register when reset asserts SHALL be discarded and not counted again.
REQ-032: The first grant after reset release SHALL search from source 0.

Verification
REQ-033: Reset, then all 4 sources valid continuously, pkt_ready_i=1 -> pkt_src_o sequence 0,1,2,3,0,...; pkt_cnt_o=8 after 8 accepts.
REQ-034: Only source 2 valid with hdr=0xA5, pkt_ready_i=0 for 5 cycles -> hdr_o=0xA5 stable; src_pkt_ready_o=0 after the first grant; one packet counted.
REQ-035: Source 1 (VC 3) and source 2 (VC 5) valid, vc_block_i[3]=1 -> source 2 granted; after vc_block_i[3]=0, source 1 granted next.
REQ-036: rr_ptr=3, only sources 0 and 3 valid -> grant 3, then 0 (wrap-around).
REQ-037: Preload pkt_cnt_o to 0xFFFF, then one accept -> pkt_cnt_o=0x0000.
REQ-038: Assert reset while pkt_valid_o=1 -> pkt_valid_o=0 at once; after release, lowest eligible source granted first.

Source files
------------

// File: rtl/eci_hdr_rr_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : eci_hdr_rr_arb_if
// Brief    : Source-side and merged-output bundle of the ECI header arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface eci_hdr_rr_arb_if #(
    parameter int NUM_SRC    = 4,
    parameter int HDR_WIDTH  = 64,
    parameter int SIZE_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    localparam int c_SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC*HDR_WIDTH-1:0]  src_hdr_i;
    logic [NUM_SRC*SIZE_WIDTH-1:0] src_pkt_size_i;
    logic [NUM_SRC*4-1:0]          src_pkt_vc_i;
    logic [NUM_SRC-1:0]            src_pkt_valid_i;
    logic [NUM_SRC-1:0]            src_pkt_ready_o;
    logic [15:0]                   vc_block_i;
    logic [HDR_WIDTH-1:0]          hdr_o;
    logic [SIZE_WIDTH-1:0]         pkt_size_o;
    logic [3:0]                    pkt_vc_o;
    logic [c_SRC_W-1:0]            pkt_src_o;
    logic                          pkt_valid_o;
    logic                          pkt_ready_i;
    logic [CNT_WIDTH-1:0]          pkt_cnt_o;

    modport slave (
        input  src_hdr_i, src_pkt_size_i, src_pkt_vc_i, src_pkt_valid_i,
        input  vc_block_i, pkt_ready_i,
        output src_pkt_ready_o, hdr_o, pkt_size_o, pkt_vc_o, pkt_src_o,
        output pkt_valid_o, pkt_cnt_o
    );

    modport master (
        output src_hdr_i, src_pkt_size_i, src_pkt_vc_i, src_pkt_valid_i,
        output vc_block_i, pkt_ready_i,
        input  src_pkt_ready_o, hdr_o, pkt_size_o, pkt_vc_o, pkt_src_o,
        input  pkt_valid_o, pkt_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/eci_hdr_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : eci_hdr_rr_arb
// Brief    : Round-robin merge of NUM_SRC header streams into one registered
//            output, with per-VC blocking and an accepted-packet counter.
// Revision : 1.0 - initial release
// ============================================================================
module eci_hdr_rr_arb #(
    parameter int NUM_SRC    = 4,
    parameter int HDR_WIDTH  = 64,
    parameter int SIZE_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    eci_hdr_rr_arb_if.slave     bus
);
    localparam int c_SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    w_eligible;
    logic                  w_found;
    logic [c_SRC_W-1:0]    w_grant_idx;
    logic [c_SRC_W:0]      w_probe;
    logic [c_SRC_W-1:0]    w_ptr_next;
    logic                  w_load_en;
    logic                  w_take;
    logic [NUM_SRC-1:0]    w_ready;

    logic                  r_valid;
    logic [c_SRC_W-1:0]    r_ptr;
    logic [HDR_WIDTH-1:0]  r_hdr;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [3:0]            r_vc;
    logic [c_SRC_W-1:0]    r_src;
    logic [CNT_WIDTH-1:0]  r_cnt;

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_elig
            assign w_eligible[k] = bus.src_pkt_valid_i[k] &
                                   ~bus.vc_block_i[bus.src_pkt_vc_i[k*4 +: 4]];
        end
    endgenerate

    // Search upward from r_ptr, wrapping; first eligible hit wins.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_probe     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_probe = {1'b0, r_ptr} + (c_SRC_W+1)'(i);
            if (w_probe >= (c_SRC_W+1)'(NUM_SRC)) begin
                w_probe = w_probe - (c_SRC_W+1)'(NUM_SRC);
            end
            if (!w_found && w_eligible[w_probe[c_SRC_W-1:0]]) begin
                w_found     = 1'b1;
                w_grant_idx = w_probe[c_SRC_W-1:0];
            end
        end
    end

    assign w_load_en  = !r_valid || bus.pkt_ready_i;
    assign w_take     = w_load_en && w_found && !reset;
    assign w_ptr_next = (w_grant_idx == c_SRC_W'(NUM_SRC-1)) ? '0
                                                             : w_grant_idx + c_SRC_W'(1);

    always_comb begin
        w_ready = '0;
        if (w_take) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    // Output fields hold when nothing is granted; only valid drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ptr   <= '0;
            r_hdr   <= '0;
            r_size  <= '0;
            r_vc    <= '0;
            r_src   <= '0;
            r_cnt   <= '0;
        end else if (w_load_en) begin
            r_valid <= w_found;
            if (w_found) begin
                r_hdr  <= bus.src_hdr_i[w_grant_idx*HDR_WIDTH +: HDR_WIDTH];
                r_size <= bus.src_pkt_size_i[w_grant_idx*SIZE_WIDTH +: SIZE_WIDTH];
                r_vc   <= bus.src_pkt_vc_i[w_grant_idx*4 +: 4];
                r_src  <= w_grant_idx;
                r_ptr  <= w_ptr_next;
                r_cnt  <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.src_pkt_ready_o = w_ready;
    assign bus.hdr_o           = r_hdr;
    assign bus.pkt_size_o      = r_size;
    assign bus.pkt_vc_o        = r_vc;
    assign bus.pkt_src_o       = r_src;
    assign bus.pkt_valid_o     = r_valid;
    assign bus.pkt_cnt_o       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_eci_hdr_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_eci_hdr_rr_arb
// Brief    : Scoreboard bench for eci_hdr_rr_arb (counter narrowed to 8 bits
//            so the wrap is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eci_hdr_rr_arb;
    localparam int N  = 4;
    localparam int HW = 64;
    localparam int SW = 5;
    localparam int CW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    eci_hdr_rr_arb_if #(.NUM_SRC(N), .HDR_WIDTH(HW), .SIZE_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

    eci_hdr_rr_arb #(.NUM_SRC(N), .HDR_WIDTH(HW), .SIZE_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]    src;
        logic [HW-1:0] hdr;
        logic [SW-1:0] size;
        logic [3:0]    vc;
    } pkt_t;

    pkt_t q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    logic m_valid;
    int   m_ptr;
    int   m_cnt;

    task automatic set_src(input int k, input logic v, input logic [HW-1:0] h,
                           input logic [3:0] vc, input logic [SW-1:0] sz);
        bus.src_pkt_valid_i[k]        = v;
        bus.src_hdr_i[k*HW +: HW]     = h;
        bus.src_pkt_vc_i[k*4 +: 4]    = vc;
        bus.src_pkt_size_i[k*SW +: SW] = sz;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ptr   = 0;
        m_cnt   = 0;
        q.delete();
    endtask

    // Called at a negedge with inputs already driven; returns at next negedge.
    task automatic step();
        int         g;
        logic       load_en;
        logic [3:0] exp_ready;
        pkt_t       e;
        #1;
        load_en = !m_valid || bus.pkt_ready_i;
        g = -1;
        if (load_en) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (g < 0 && bus.src_pkt_valid_i[k] &&
                    !bus.vc_block_i[bus.src_pkt_vc_i[k*4 +: 4]]) g = k;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        tests_run++;
        if (bus.src_pkt_ready_o !== exp_ready) begin
            tests_failed++;
            $display("FAIL ready: got %b expected %b at %0t", bus.src_pkt_ready_o, exp_ready, $time);
        end
        tests_run++;
        if (bus.pkt_valid_o !== m_valid) begin
            tests_failed++;
            $display("FAIL valid: got %b expected %b at %0t", bus.pkt_valid_o, m_valid, $time);
        end
        if (m_valid) begin
            tests_run++;
            if (q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard: output valid with empty queue at %0t", $time);
            end else begin
                e = q[0];
                if (bus.pkt_src_o !== e.src || bus.hdr_o !== e.hdr ||
                    bus.pkt_size_o !== e.size || bus.pkt_vc_o !== e.vc) begin
                    tests_failed++;
                    $display("FAIL pkt: got src=%0d hdr=%h size=%0d vc=%0d expected src=%0d hdr=%h size=%0d vc=%0d at %0t",
                             bus.pkt_src_o, bus.hdr_o, bus.pkt_size_o, bus.pkt_vc_o,
                             e.src, e.hdr, e.size, e.vc, $time);
                end
                if (bus.pkt_ready_i) void'(q.pop_front());
            end
        end
        if (load_en) begin
            if (g >= 0) begin
                e.src  = 2'(g);
                e.hdr  = bus.src_hdr_i[g*HW +: HW];
                e.size = bus.src_pkt_size_i[g*SW +: SW];
                e.vc   = bus.src_pkt_vc_i[g*4 +: 4];
                q.push_back(e);
                m_valid = 1'b1;
                m_ptr   = (g + 1) % N;
                m_cnt   = (m_cnt + 1) % (1 << CW);
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.pkt_cnt_o !== CW'(m_cnt)) begin
            tests_failed++;
            $display("FAIL cnt: got %0d expected %0d at %0t", bus.pkt_cnt_o, m_cnt, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if (bus.pkt_valid_o !== 1'b0 || bus.src_pkt_ready_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_async: valid=%b ready=%b expected 0/0", bus.pkt_valid_o, bus.src_pkt_ready_o);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        bus.src_pkt_valid_i = '0;
        bus.pkt_ready_i     = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        bus.src_pkt_valid_i = '0;
        bus.src_hdr_i       = '0;
        bus.src_pkt_size_i  = '0;
        bus.src_pkt_vc_i    = '0;
        bus.vc_block_i      = '0;
        bus.pkt_ready_i     = 1'b1;
        set_src(0, 1'b1, 64'h1111, 4'd0, 5'd1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.src_pkt_ready_o !== '0 || bus.pkt_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl: ready=%b valid=%b expected 0/0", bus.src_pkt_ready_o, bus.pkt_valid_o);
        end
        tests_run++;
        if (bus.hdr_o !== '0 || bus.pkt_size_o !== '0 || bus.pkt_vc_o !== '0 ||
            bus.pkt_src_o !== '0 || bus.pkt_cnt_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: hdr=%h size=%0d vc=%0d src=%0d cnt=%0d expected all 0",
                     bus.hdr_o, bus.pkt_size_o, bus.pkt_vc_o, bus.pkt_src_o, bus.pkt_cnt_o);
        end
        bus.src_pkt_valid_i = '0;
        model_reset();
        reset = 1'b0;
        step();
    endtask

    task automatic test_rotation();
        logic [1:0] exp_src;
        do_reset();
        for (int k = 0; k < N; k++) set_src(k, 1'b1, 64'hC0DE_0000 + 64'(k), 4'(k), 5'(k + 1));
        bus.pkt_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_src = 2'(i % N);
            tests_run++;
            if (bus.pkt_src_o !== exp_src) begin
                tests_failed++;
                $display("FAIL rotation[%0d]: got src %0d expected %0d", i, bus.pkt_src_o, exp_src);
            end
        end
        tests_run++;
        if (bus.pkt_cnt_o !== 8'd8) begin
            tests_failed++;
            $display("FAIL rotation_cnt: got %0d expected 8", bus.pkt_cnt_o);
        end
        drain();
    endtask

    task automatic test_stall();
        int c0;
        c0 = m_cnt;
        set_src(2, 1'b1, 64'hA5, 4'd0, 5'd3);
        bus.pkt_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (bus.hdr_o !== 64'hA5 || bus.pkt_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: got hdr=%h valid=%b expected a5/1", i, bus.hdr_o, bus.pkt_valid_o);
            end
        end
        tests_run++;
        if (bus.pkt_cnt_o !== CW'(c0 + 1)) begin
            tests_failed++;
            $display("FAIL stall_cnt: got %0d expected %0d", bus.pkt_cnt_o, CW'(c0 + 1));
        end
        drain();
    endtask

    task automatic test_vc_block();
        bus.src_pkt_valid_i = '0;
        set_src(1, 1'b1, 64'hB1, 4'd3, 5'd4);
        set_src(2, 1'b1, 64'hB2, 4'd5, 5'd6);
        bus.vc_block_i  = 16'h0008;
        bus.pkt_ready_i = 1'b1;
        step();
        tests_run++;
        if (bus.pkt_src_o !== 2'd2) begin
            tests_failed++;
            $display("FAIL vc_block: got src %0d expected 2", bus.pkt_src_o);
        end
        bus.vc_block_i = '0;
        step();
        tests_run++;
        if (bus.pkt_src_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL vc_unblock: got src %0d expected 1", bus.pkt_src_o);
        end
        drain();
    endtask

    task automatic test_wrap();
        bus.src_pkt_valid_i = '0;
        bus.pkt_ready_i     = 1'b1;
        set_src(2, 1'b1, 64'hD2, 4'd1, 5'd1);
        step();
        bus.src_pkt_valid_i = '0;
        set_src(0, 1'b1, 64'hD0, 4'd2, 5'd2);
        set_src(3, 1'b1, 64'hD3, 4'd4, 5'd7);
        step();
        tests_run++;
        if (bus.pkt_src_o !== 2'd3) begin
            tests_failed++;
            $display("FAIL wrap_first: got src %0d expected 3", bus.pkt_src_o);
        end
        step();
        tests_run++;
        if (bus.pkt_src_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL wrap_second: got src %0d expected 0", bus.pkt_src_o);
        end
        drain();
    endtask

    task automatic test_cnt_wrap();
        do_reset();
        bus.src_pkt_valid_i = '0;
        set_src(0, 1'b1, 64'hE0, 4'd0, 5'd1);
        bus.pkt_ready_i = 1'b1;
        repeat (255) step();
        tests_run++;
        if (bus.pkt_cnt_o !== 8'hFF) begin
            tests_failed++;
            $display("FAIL cnt_full: got %h expected ff", bus.pkt_cnt_o);
        end
        step();
        tests_run++;
        if (bus.pkt_cnt_o !== 8'h00) begin
            tests_failed++;
            $display("FAIL cnt_wrap: got %h expected 00", bus.pkt_cnt_o);
        end
        drain();
    endtask

    task automatic test_reset_inflight();
        bus.src_pkt_valid_i = '0;
        set_src(1, 1'b1, 64'hF1, 4'd6, 5'd2);
        set_src(3, 1'b1, 64'hF3, 4'd7, 5'd9);
        bus.pkt_ready_i = 1'b0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.pkt_valid_o !== 1'b0 || bus.src_pkt_ready_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_inflight: valid=%b ready=%b expected 0/0", bus.pkt_valid_o, bus.src_pkt_ready_o);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.pkt_ready_i = 1'b1;
        step();
        tests_run++;
        if (bus.pkt_src_o !== 2'd1 || bus.pkt_cnt_o !== 8'd1) begin
            tests_failed++;
            $display("FAIL post_reset_grant: got src=%0d cnt=%0d expected 1/1", bus.pkt_src_o, bus.pkt_cnt_o);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < N; k++) begin
                set_src(k, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                        4'($urandom_range(0, 15)), 5'($urandom));
            end
            bus.vc_block_i  = 16'($urandom & $urandom);
            bus.pkt_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_rotation();
        test_stall();
        test_vc_block();
        test_wrap();
        test_cnt_wrap();
        test_reset_inflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
